// File: rtl/ds1302_pkg.sv
// Shared states and constants for the DS1302 bit-level serial engine.
package ds1302_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    RECOVER,
    DONE,
    GAP
  } state_e;

  localparam int CALL_WR = 1;
  localparam int CALL_RD = 0;

  localparam logic [3:0] LAST_SLOT = 4'd15;

endpackage

// File: rtl/ds1302_tick_timer.sv
// Loadable 16-bit down-counter; tc_o flags a count of zero.
module ds1302_tick_timer (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        load_i,
  input  logic [15:0] val_i,
  output logic        tc_o
);

  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = val_i;
    end else if (cnt_q != 16'd0) begin
      cnt_d = cnt_q - 16'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == 16'd0);

endmodule

// File: rtl/ds1302_funcmod.sv
// DS1302 single-byte transfer engine: CE/SCLK/SIO sequencing,
// LSB-first shift out, and read-back capture.
module ds1302_funcmod
  import ds1302_pkg::*;
#(
  parameter int unsigned HALF     = 50,
  parameter int unsigned CE_SETUP = 200,
  parameter int unsigned CE_IDLE  = 200
) (
  input  logic       CLOCK,
  input  logic       RST_n,
  input  logic [1:0] iCall,
  input  logic [7:0] iAddr,
  input  logic [7:0] iData,
  output logic       oDone,
  output logic [7:0] oData,
  output logic       RTC_CE,
  output logic       RTC_SCLK,
  inout  wire        RTC_SIO
);

  localparam logic [15:0] HALF_LD  = 16'(HALF - 1);
  localparam logic [15:0] SETUP_LD = 16'(CE_SETUP - 1);
  localparam logic [15:0] IDLE_LD  = 16'(CE_IDLE - 1);

  state_e      state_q, state_d;
  logic        wr_q, wr_d;
  logic        hi_q, hi_d;
  logic [3:0]  bit_q, bit_d;
  logic [7:0]  sh_q, sh_d;
  logic [7:0]  data_q, data_d;
  logic [7:0]  odata_q, odata_d;
  logic        tld;
  logic [15:0] tval;
  logic        tc;
  logic        sio_in;
  logic        sio_oe;

  ds1302_tick_timer u_tmr (
    .clk_i  (CLOCK),
    .rst_ni (RST_n),
    .load_i (tld),
    .val_i  (tval),
    .tc_o   (tc)
  );

  assign sio_in = RTC_SIO;

  always_comb begin
    state_d = state_q;
    wr_d    = wr_q;
    hi_d    = hi_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    data_d  = data_q;
    odata_d = odata_q;
    tld     = 1'b0;
    tval    = HALF_LD;
    unique case (state_q)
      IDLE: begin
        if (iCall != 2'b00) begin
          state_d = SETUP;
          wr_d    = iCall[CALL_WR];
          sh_d    = iAddr;
          data_d  = iData;
          tld     = 1'b1;
          tval    = SETUP_LD;
        end
      end
      SETUP: begin
        if (tc) begin
          state_d = SHIFT;
          hi_d    = 1'b0;
          bit_d   = 4'd0;
          tld     = 1'b1;
        end
      end
      SHIFT: begin
        if (tc) begin
          tld = 1'b1;
          if (!hi_q) begin
            hi_d = 1'b1;
            // read data is captured at the end of each low phase
            if (!wr_q && bit_q[3]) begin
              sh_d = {sio_in, sh_q[7:1]};
            end
          end else if (bit_q == LAST_SLOT) begin
            state_d = HOLD;
          end else begin
            hi_d  = 1'b0;
            bit_d = bit_q + 4'd1;
            if (bit_q == 4'd7) begin
              sh_d = data_q;
            end else if (wr_q || !bit_q[3]) begin
              sh_d = sh_q >> 1;
            end
          end
        end
      end
      HOLD: begin
        if (tc) begin
          state_d = RECOVER;
          tld     = 1'b1;
          tval    = IDLE_LD;
        end
      end
      RECOVER: begin
        if (tc) begin
          state_d = DONE;
          if (!wr_q) begin
            odata_d = sh_q;
          end
        end
      end
      DONE:    state_d = GAP;
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK) begin
    if (!RST_n) begin
      state_q <= IDLE;
      wr_q    <= 1'b0;
      hi_q    <= 1'b0;
      bit_q   <= '0;
      sh_q    <= '0;
      data_q  <= '0;
      odata_q <= '0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      hi_q    <= hi_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      data_q  <= data_d;
      odata_q <= odata_d;
    end
  end

  assign RTC_CE   = (state_q == SETUP) || (state_q == SHIFT) ||
                    (state_q == HOLD);
  assign RTC_SCLK = (state_q == SHIFT) && hi_q;
  assign sio_oe   = (state_q == SETUP) ||
                    ((state_q == SHIFT) && (wr_q || !bit_q[3]));
  assign RTC_SIO  = sio_oe ? sh_q[0] : 1'bz;
  assign oDone    = (state_q == DONE);
  assign oData    = odata_q;

endmodule
